mat_stream_tx: RTL and testbench

Ping-pong buffered transmitter for the 4x4 complex channel-matrix stream. It accepts matrix elements over a random-access write port and commits them as complete frames. It then emits each frame as 16 back-to-back samples on a valid/R/I stream, the same format the bidiagonalization top consumes. A forced idle gap follows every frame, so the consumer's end-of-receive (valid falling) is always seen. Two banks let the host load frame N+1 while frame N is streaming.

---
 rtl/mat_stream_tx.sv | 217 +++++++++++++++++++++
 tb/tb_mat_stream_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_stream_tx.sv
// mat_stream_tx: ping-pong buffered transmitter for the 4x4 complex
// channel-matrix stream.
//
// The host fills one bank through a random-access write port and commits it
// as a frame. Committed frames are emitted as CHANNEL_SIZE back-to-back
// samples on a valid/R/I stream, in ascending element order, with no stalls.
// A forced idle gap of GAP_CYCLES cycles follows every frame, so the consumer
// always sees valid fall. Two banks let the host load frame N+1 while frame N
// is streaming.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   wr_en       write one element into the current fill bank
//   wr_addr     element index {row,col}, row-major
//   wr_R, wr_I  signed real/imag element
//   commit      one-cycle pulse: fill bank complete, queue it for transmit
//   valid_o     stream sample valid
//   R_o, I_o    signed stream sample, zero whenever valid_o is low
//   busy        high while the stream engine is in SEND or GAP
//   frame_done  high together with the last sample of a frame
//   pending_o   committed frames not yet fully sent (0..2)
//   overflow    sticky: a commit was rejected (cleared only by rst)
module mat_stream_tx #(
  parameter int CHANNEL_SIZE = 16,
  parameter int BIT_NUM      = 18,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [3:0]                wr_addr,
  input  logic signed [BIT_NUM-1:0] wr_R,
  input  logic signed [BIT_NUM-1:0] wr_I,
  input  logic                      commit,
  output logic                      valid_o,
  output logic signed [BIT_NUM-1:0] R_o,
  output logic signed [BIT_NUM-1:0] I_o,
  output logic                      busy,
  output logic                      frame_done,
  output logic [1:0]                pending_o,
  output logic                      overflow
);

  localparam int AW = 4;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(CHANNEL_SIZE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef struct packed {
    logic signed [BIT_NUM-1:0] re;
    logic signed [BIT_NUM-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Storage: two banks, no reset (contents are don't-care until written)
  // ---------------------------------------------------------------------
  sample_t bank_mem [2][CHANNEL_SIZE];

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [1:0]    pending_q, pending_d;
  logic          fill_ptr_q, fill_ptr_d;
  logic          send_ptr_q, send_ptr_d;
  logic          overflow_q, overflow_d;

  logic          valid_q, valid_d;
  sample_t       smp_q, smp_d;
  logic          busy_q, busy_d;
  logic          fdone_q, fdone_d;

  logic          release_w;
  logic          commit_ok;
  logic          wr_ok;
  logic [1:0]    pend_rel;

  // ---------------------------------------------------------------------
  // Bank bookkeeping
  // ---------------------------------------------------------------------
  // Release is the edge that loads the last sample into the output register.
  assign release_w = (state_q == ST_SEND) && (cnt_q == LAST_IDX);

  // Release is applied before the commit decision, so a commit coinciding
  // with a release is accepted even when both banks are occupied.
  assign pend_rel  = pending_q - {1'b0, release_w};
  assign commit_ok = commit && (pend_rel < 2'd2);

  // With both banks committed the fill bank is the one about to be sent;
  // writes are dropped so queued data is never corrupted.
  assign wr_ok     = wr_en && (pending_q != 2'd2);

  always_comb begin
    pending_d  = pend_rel + {1'b0, commit_ok};
    fill_ptr_d = fill_ptr_q ^ commit_ok;
    send_ptr_d = send_ptr_q ^ release_w;
    overflow_d = overflow_q | (commit & ~commit_ok);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      bank_mem[fill_ptr_q][wr_addr] <= '{re: wr_R, im: wr_I};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= 2'd0;
      fill_ptr_q <= 1'b0;
      send_ptr_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      fill_ptr_q <= fill_ptr_d;
      send_ptr_q <= send_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stream FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stream FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != 2'd0) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          gcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        // pending_q already reflects the release of the frame just sent.
        if (gcnt_q == GAP_LAST) begin
          state_d = (pending_q != 2'd0) ? ST_SEND : ST_IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gcnt_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Stream FSM: outputs (registered, one cycle behind the state register,
  // so each GAP state cycle yields exactly one valid-low output cycle)
  // ---------------------------------------------------------------------
  always_comb begin
    valid_d = (state_q == ST_SEND);
    smp_d   = '0;
    if (state_q == ST_SEND) begin
      smp_d = bank_mem[send_ptr_q][cnt_q];
    end
    busy_d  = (state_q == ST_SEND) || (state_q == ST_GAP);
    fdone_d = release_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      smp_q   <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      smp_q   <= smp_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  assign valid_o    = valid_q;
  assign R_o        = smp_q.re;
  assign I_o        = smp_q.im;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign pending_o  = pending_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mat_stream_tx.sv
// Scoreboard bench for mat_stream_tx: stimulus pushes expected samples when
// it commits a frame; a negedge monitor pops and compares every valid sample
// and checks zeroed outputs, frame length and gap length.
module tb_mat_stream_tx;
  localparam int BIT_NUM    = 18;
  localparam int GAP_CYCLES = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      wr_en;
  logic [3:0]                wr_addr;
  logic signed [BIT_NUM-1:0] wr_R, wr_I;
  logic                      commit;
  logic                      valid_o;
  logic signed [BIT_NUM-1:0] R_o, I_o;
  logic                      busy, frame_done, overflow;
  logic [1:0]                pending_o;

  mat_stream_tx #(.CHANNEL_SIZE(16), .BIT_NUM(BIT_NUM), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_R(wr_R), .wr_I(wr_I),
    .commit(commit), .valid_o(valid_o), .R_o(R_o), .I_o(I_o), .busy(busy),
    .frame_done(frame_done), .pending_o(pending_o), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int i; bit fd; } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int last_gap = 0;
  int run_len = 0;
  int gap_len = 1000;
  bit skip_len = 0;
  bit prev_valid = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (valid_o) begin
      if (!prev_valid) begin
        last_gap = gap_len;
        if (gap_len < 1000) check("gap_min", longint'(gap_len >= GAP_CYCLES), 1);
        run_len = 0;
      end
      run_len++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample actual R=%0d I=%0d expected no sample", R_o, I_o);
      end else begin
        e = q.pop_front();
        check("sample_R", R_o, e.r);
        check("sample_I", I_o, e.i);
        check("sample_frame_done", frame_done, e.fd);
      end
      gap_len = 0;
      if (rst) skip_len = 1;   // frame aborted by reset; length check waived
    end else begin
      if (prev_valid) begin
        if (!skip_len) check("frame_len", run_len, 16);
        skip_len = 0;
      end
      if (gap_len < 1000) gap_len++;
      check("idle_R_zero", R_o, 0);
      check("idle_I_zero", I_o, 0);
      check("idle_frame_done", frame_done, 0);
    end
    if (rst) gap_len = 1000;
    prev_valid = valid_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int r, input int i);
    wr_en = 1'b1; wr_addr = 4'(a); wr_R = 18'(r); wr_I = 18'(i);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic push(input int r, input int i, input bit fd);
    exp_t e;
    e.r = r; e.i = i; e.fd = fd;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || valid_o || busy || pending_o != 2'd0) && n < 400) begin
      tick();
      n++;
    end
    check({nm, "_timeout"}, longint'(n < 400), 1);
    check({nm, "_pending_zero"}, pending_o, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_R = '0; wr_I = '0; commit = 1'b0;
    tick(); tick();
    check("rst_valid", valid_o, 0);
    check("rst_R", R_o, 0);
    check("rst_I", I_o, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pending", pending_o, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // 1) single frame R=k, I=-k, latency check
    for (int k = 0; k < 16; k++) wr(k, k, -k);
    for (int k = 0; k < 16; k++) push(k, -k, k == 15);
    do_commit();                                  // edge t
    check("t1_pending_after_commit", pending_o, 1);
    check("t1_valid_t0", valid_o, 0);
    tick();                                       // t+1
    check("t1_valid_t1", valid_o, 0);
    tick();                                       // t+2
    check("t1_valid_t2", valid_o, 1);
    check("t1_busy_t2", busy, 1);
    wait_idle("t1");

    // 2) ping-pong: A committed, B loaded during A and committed mid-A
    for (int k = 0; k < 16; k++) wr(k, 100 + k, -100 - k);
    for (int k = 0; k < 16; k++) push(100 + k, -100 - k, k == 15);
    do_commit();                                  // edge t
    check("pp_pending_1", pending_o, 1);
    for (int k = 0; k < 15; k++) wr(k, 200 + k, -200 - k);   // t+1..t+15
    for (int k = 0; k < 16; k++) push(200 + k, -200 - k, k == 15);
    commit = 1'b1;
    wr(15, 215, -215);                            // write + commit on t+16
    commit = 1'b0;
    check("pp_pending_2", pending_o, 2);
    tick();                                       // t+17: A's last sample
    check("pp_A_last_R", R_o, 115);
    check("pp_A_frame_done", frame_done, 1);
    check("pp_pending_1b", pending_o, 1);
    wait_idle("pp");
    check("pp_gap_exact", last_gap, GAP_CYCLES);

    // 3) overflow: A, partial B, rejected C, fresh C on A's release edge
    for (int k = 0; k < 16; k++) wr(k, 400 + k, k);
    for (int k = 0; k < 16; k++) push(400 + k, k, k == 15);
    do_commit();                                  // edge t
    for (int k = 0; k < 8; k++) wr(k, 500 + k, -500 - k);    // t+1..t+8
    // B reuses the bank that held ping-pong B: elements 8..15 are retained
    for (int k = 0; k < 16; k++)
      if (k < 8) push(500 + k, -500 - k, k == 15);
      else       push(200 + k, -200 - k, k == 15);
    do_commit();                                  // t+9
    check("of_pending_2", pending_o, 2);
    for (int k = 0; k < 4; k++) wr(k, 600 + k, 600 + k);     // t+10..t+13, dropped
    check("of_no_overflow_yet", overflow, 0);
    do_commit();                                  // t+14, rejected
    check("of_overflow_set", overflow, 1);
    check("of_pending_still_2", pending_o, 2);
    tick(); tick();                               // t+15, t+16
    check("of_overflow_sticky", overflow, 1);
    // fresh C accepted on the release edge; C writes were dropped, so the
    // committed bank still holds A's data
    for (int k = 0; k < 16; k++) push(400 + k, k, k == 15);
    do_commit();                                  // t+17
    check("of_A_last_R", R_o, 415);
    check("of_release_frame_done", frame_done, 1);
    check("of_pending_stays_2", pending_o, 2);
    wait_idle("of");
    check("of_overflow_sticky_end", overflow, 1);

    // 4) signed extremes
    wr(0, 131071, -131072);
    wr(1, -131072, 131071);
    for (int k = 2; k < 16; k++) wr(k, -1000 * k, 999 * k);
    push(131071, -131072, 0);
    push(-131072, 131071, 0);
    for (int k = 2; k < 16; k++) push(-1000 * k, 999 * k, k == 15);
    do_commit();
    wait_idle("sx");

    // 5) reset mid-frame at sample 7, then a clean frame
    for (int k = 0; k < 16; k++) wr(k, 50 + k, -50 - k);
    for (int k = 0; k < 16; k++) push(50 + k, -50 - k, k == 15);
    do_commit();
    n = 0;
    while (!(valid_o && R_o == 57) && n < 100) begin tick(); n++; end
    check("rm_reach_sample7", longint'(n < 100), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    q.delete();                                   // aborted remainder
    @(posedge clk); #1;
    check("rm_valid", valid_o, 0);
    check("rm_R", R_o, 0);
    check("rm_I", I_o, 0);
    check("rm_busy", busy, 0);
    check("rm_frame_done", frame_done, 0);
    check("rm_pending", pending_o, 0);
    check("rm_overflow_cleared", overflow, 0);
    rst = 1'b0;
    tick(); tick();
    check("rm_stays_idle", valid_o, 0);
    for (int k = 0; k < 16; k++) wr(k, 300 + k, -300 - k);
    for (int k = 0; k < 16; k++) push(300 + k, -300 - k, k == 15);
    do_commit();
    check("rm_pending_1", pending_o, 1);
    tick(); tick();
    check("rm_first_R", R_o, 300);
    wait_idle("rm");
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
